// File: rtl/btb_assoc.sv
// btb_assoc: parametrised set-associative branch target buffer with tree-PLRU replacement and a flush sequencer.
// Optional feature macro: BTB_COUNTER_EN adds 2-bit taken/not-taken counters per entry.
module btb_assoc #(
    parameter int ADDR_W = 16,
    parameter int SETS   = 8,
    parameter int WAYS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_valid,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              flush,
    output logic              busy
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - IDX_W - 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_e;

    // Each tree node points toward the victim: 0 = left subtree, 1 = right subtree.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] plru, input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] res;
        int              lvl;
        int              path;
        res = plru;
        for (int n = 0; n < WAYS - 1; n++) begin
            lvl = 0;
            for (int l = 1; l < WAY_W; l++) begin
                lvl = ((n + 1) >= (1 << l)) ? l : lvl;
            end
            path = (1 << lvl) + (int'(way) >> (WAY_W - lvl));
            if (path == n + 1) begin
                res[n] = ~way[WAY_W-1-lvl];
            end else begin
                res[n] = plru[n];
            end
        end
        return res;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] plru);
        int   node;
        logic dir;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            dir = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) begin
                dir = (n == node - 1) ? plru[n] : dir;
            end
            node = 2 * node + (dir ? 1 : 0);
        end
        return WAY_W'(node - WAYS);
    endfunction

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [WAYS-2:0]   plru_q  [SETS];
    logic [WAYS-2:0]   plru_d  [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
    logic [ADDR_W-1:0] tgt_q   [SETS][WAYS];
    logic [ADDR_W-1:0] tgt_d   [SETS][WAYS];
`ifdef BTB_COUNTER_EN
    logic [1:0]        ctr_q   [SETS][WAYS];
    logic [1:0]        ctr_d   [SETS][WAYS];
`endif
    logic              pred_valid_q, pred_valid_d;
    logic              pred_hit_q, pred_hit_d;
    logic              pred_taken_q, pred_taken_d;
    logic [ADDR_W-1:0] pred_target_q, pred_target_d;

    logic [IDX_W-1:0]  lk_idx_s, up_idx_s;
    logic [TAG_W-1:0]  lk_tag_s, up_tag_s;
    logic [WAYS-1:0]   lk_hv_s, up_hv_s;
    logic [WAY_W-1:0]  lk_way_s, up_way_s, alloc_way_s;
    logic              lk_hit_s, up_hit_s, lk_taken_s, idle_s, upd_en_s;
    logic              unused_pc_lsb_s;

    assign lk_idx_s        = lookup_pc[IDX_W:1];
    assign lk_tag_s        = lookup_pc[ADDR_W-1:IDX_W+1];
    assign up_idx_s        = upd_pc[IDX_W:1];
    assign up_tag_s        = upd_pc[ADDR_W-1:IDX_W+1];
    assign unused_pc_lsb_s = lookup_pc[0] ^ upd_pc[0];
    assign idle_s          = (state_q == S_IDLE);
    assign upd_en_s        = upd_valid & idle_s;

    // Tag compare for the lookup and update ports; at most one way hits, so OR-ing way numbers is exact.
    always_comb begin
        lk_hv_s  = '0;
        up_hv_s  = '0;
        lk_way_s = '0;
        up_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            lk_hv_s[w] = valid_q[lk_idx_s][w] & (tag_q[lk_idx_s][w] == lk_tag_s);
            up_hv_s[w] = valid_q[up_idx_s][w] & (tag_q[up_idx_s][w] == up_tag_s);
            lk_way_s   = lk_way_s | (lk_hv_s[w] ? WAY_W'(w) : '0);
            up_way_s   = up_way_s | (up_hv_s[w] ? WAY_W'(w) : '0);
        end
        lk_hit_s = |lk_hv_s;
        up_hit_s = |up_hv_s;
    end

    // Victim selection: lowest-numbered invalid way, else the PLRU choice.
    always_comb begin
        alloc_way_s = plru_victim(plru_q[up_idx_s]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            alloc_way_s = valid_q[up_idx_s][w] ? alloc_way_s : WAY_W'(w);
        end
    end

`ifdef BTB_COUNTER_EN
    assign lk_taken_s = ctr_q[lk_idx_s][lk_way_s][1];
`else
    assign lk_taken_s = 1'b1;
`endif

    // Next-state: flush sequencer, prediction registers, lookup touch and branch update.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        plru_d        = plru_q;
        tag_d         = tag_q;
        tgt_d         = tgt_q;
`ifdef BTB_COUNTER_EN
        ctr_d         = ctr_q;
`endif
        pred_valid_d  = lookup_valid;
        pred_hit_d    = pred_hit_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                valid_d[cnt_q] = '0;
                plru_d[cnt_q]  = '0;
                if (flush) begin
                    cnt_d = '0;
                end else if (cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (lookup_valid) begin
            pred_hit_d    = lk_hit_s & idle_s;
            pred_taken_d  = lk_hit_s & idle_s & lk_taken_s;
            pred_target_d = (lk_hit_s & idle_s) ? tgt_q[lk_idx_s][lk_way_s] : '0;
        end else begin
            pred_hit_d    = pred_hit_q;
        end

        // Lookup touch first; an update touch to the same set below overrides it.
        if (lookup_valid & idle_s & lk_hit_s) begin
            plru_d[lk_idx_s] = plru_touch(plru_q[lk_idx_s], lk_way_s);
        end else begin
            plru_d[lk_idx_s] = plru_d[lk_idx_s];
        end

        if (upd_en_s & up_hit_s) begin
            tgt_d[up_idx_s][up_way_s] = upd_target;
            plru_d[up_idx_s]          = plru_touch(plru_q[up_idx_s], up_way_s);
`ifdef BTB_COUNTER_EN
            if (upd_taken) begin
                ctr_d[up_idx_s][up_way_s] = (ctr_q[up_idx_s][up_way_s] == 2'b11) ? 2'b11 : ctr_q[up_idx_s][up_way_s] + 2'b01;
            end else begin
                ctr_d[up_idx_s][up_way_s] = (ctr_q[up_idx_s][up_way_s] == 2'b00) ? 2'b00 : ctr_q[up_idx_s][up_way_s] - 2'b01;
            end
`else
            valid_d[up_idx_s][up_way_s] = upd_taken;
`endif
        end else if (upd_en_s & upd_taken) begin
            valid_d[up_idx_s][alloc_way_s] = 1'b1;
            tag_d[up_idx_s][alloc_way_s]   = up_tag_s;
            tgt_d[up_idx_s][alloc_way_s]   = upd_target;
            plru_d[up_idx_s]               = plru_touch(plru_q[up_idx_s], alloc_way_s);
`ifdef BTB_COUNTER_EN
            ctr_d[up_idx_s][alloc_way_s]   = 2'b10;
`endif
        end else begin
            state_d = state_d;
        end
    end

    // Control state, valid/PLRU/counter arrays and prediction outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
`ifdef BTB_COUNTER_EN
                for (int w = 0; w < WAYS; w++) begin
                    ctr_q[s][w] <= 2'b00;
                end
`endif
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pred_valid_q  <= pred_valid_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            valid_q       <= valid_d;
            plru_q        <= plru_d;
`ifdef BTB_COUNTER_EN
            ctr_q         <= ctr_d;
`endif
        end
    end

    // Tag and target storage carries no reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    assign pred_valid  = pred_valid_q;
    assign pred_hit    = pred_hit_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign busy        = (state_q == S_FLUSH);

endmodule

// File: tb/tb_btb_assoc.sv
// Randomised self-checking bench for btb_assoc against an array-based reference model.
module tb_btb_assoc;
    localparam int SETS  = 8;
    localparam int WAYS  = 4;
    localparam int WAY_W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid, upd_valid, upd_taken, flush;
    logic [15:0] lookup_pc, upd_pc, upd_target;
    logic        pred_valid, pred_hit, pred_taken, busy;
    logic [15:0] pred_target;

    int n_checks = 0;
    int n_errors = 0;

    btb_assoc #(.ADDR_W(16), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    // reference model state
    bit   m_valid [SETS][WAYS];
    int   m_tag   [SETS][WAYS];
    int   m_tgt   [SETS][WAYS];
    int   m_ctr   [SETS][WAYS];
    int   m_plru  [SETS];
    bit   m_busy;
    int   m_cnt;
    logic e_pv, e_ph, e_pt, e_busy;
    logic [15:0] e_tgt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_touch(input int p, input int w);
        int node;
        for (int l = 0; l < WAY_W; l++) begin
            node = (1 << l) + (w >> (WAY_W - l));
            if (((w >> (WAY_W - 1 - l)) & 1) == 1) p = p & ~(1 << (node - 1));
            else                                   p = p | (1 << (node - 1));
        end
        return p;
    endfunction

    function automatic int m_victim(input int p);
        int node = 1;
        for (int l = 0; l < WAY_W; l++) node = 2 * node + ((p >> (node - 1)) & 1);
        return node - WAYS;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            m_plru[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_ctr[s][w]   = 0;
            end
        end
        m_busy = 0; m_cnt = 0;
        e_pv = 0; e_ph = 0; e_pt = 0; e_tgt = 16'h0000; e_busy = 0;
    endtask

    // Advance the model by one clock using the current inputs, then compare after the edge.
    task automatic step();
        int  ls, lt, lw, us, ut, uw;
        bit  lh, uh, utouch;
        lh = 0; lw = 0; uh = 0; uw = -1; utouch = 0;
        ls = int'(lookup_pc[3:1]); lt = int'(lookup_pc[15:4]);
        us = int'(upd_pc[3:1]);    ut = int'(upd_pc[15:4]);
        e_pv = lookup_valid;
        if (lookup_valid) begin
            for (int w = 0; w < WAYS; w++)
                if (!m_busy && m_valid[ls][w] && m_tag[ls][w] == lt) begin lh = 1; lw = w; end
`ifdef BTB_COUNTER_EN
            e_pt = lh && (m_ctr[ls][lw] >= 2);
`else
            e_pt = lh;
`endif
            e_ph  = lh;
            e_tgt = lh ? 16'(m_tgt[ls][lw]) : 16'h0000;
        end
        if (upd_valid && !m_busy) begin
            for (int w = 0; w < WAYS; w++)
                if (m_valid[us][w] && m_tag[us][w] == ut) begin uh = 1; uw = w; end
            if (uh) begin
                utouch = 1;
                m_tgt[us][uw] = int'(upd_target);
`ifdef BTB_COUNTER_EN
                if (upd_taken) m_ctr[us][uw] = (m_ctr[us][uw] < 3) ? m_ctr[us][uw] + 1 : 3;
                else           m_ctr[us][uw] = (m_ctr[us][uw] > 0) ? m_ctr[us][uw] - 1 : 0;
`else
                if (!upd_taken) m_valid[us][uw] = 0;
`endif
            end else if (upd_taken) begin
                utouch = 1;
                for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[us][w]) uw = w;
                if (uw < 0) uw = m_victim(m_plru[us]);
                m_valid[us][uw] = 1; m_tag[us][uw] = ut; m_tgt[us][uw] = int'(upd_target); m_ctr[us][uw] = 2;
            end
        end
        if (lh && !(utouch && us == ls)) m_plru[ls] = m_touch(m_plru[ls], lw);
        if (utouch) m_plru[us] = m_touch(m_plru[us], uw);
        if (m_busy) begin
            m_plru[m_cnt] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[m_cnt][w] = 0;
            if (flush) m_cnt = 0;
            else if (m_cnt == SETS - 1) m_busy = 0;
            else m_cnt++;
        end else if (flush) begin
            m_busy = 1; m_cnt = 0;
        end
        e_busy = m_busy;
        @(posedge clk); #1;
        check("pred_valid", 32'(pred_valid), 32'(e_pv));
        check("pred_hit", 32'(pred_hit), 32'(e_ph));
        check("pred_taken", 32'(pred_taken), 32'(e_pt));
        check("pred_target", 32'(pred_target), 32'(e_tgt));
        check("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic idle_in();
        lookup_valid = 0; lookup_pc = 16'h0000; upd_valid = 0; upd_pc = 16'h0000;
        upd_target = 16'h0000; upd_taken = 0; flush = 0;
    endtask

    task automatic do_lookup(input logic [15:0] pc);
        idle_in(); lookup_valid = 1; lookup_pc = pc; step();
    endtask

    task automatic do_update(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
        idle_in(); upd_valid = 1; upd_pc = pc; upd_target = tgt; upd_taken = tk; step();
    endtask

    initial begin
        int n_busy;
        rst_n = 0; idle_in(); m_reset();
        #23;
        check("rst_pred_valid", 32'(pred_valid), 32'h0);
        check("rst_pred_hit", 32'(pred_hit), 32'h0);
        check("rst_pred_target", 32'(pred_target), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        #3 rst_n = 1;
        @(posedge clk); #1;

        do_lookup(16'h3000);
        check("cold_hit", 32'(pred_hit), 32'h0);
        do_update(16'h3002, 16'h3040, 1'b1);
        do_lookup(16'h3002);
        check("alloc_target", 32'(pred_target), 32'h3040);
        check("alloc_taken", 32'(pred_taken), 32'h1);
        do_update(16'h3002, 16'h3040, 1'b0);
        do_update(16'h3002, 16'h3040, 1'b0);
        do_lookup(16'h3002);
        check("nt_taken", 32'(pred_taken), 32'h0);

        // flush with entries present; update during busy must be dropped
        do_update(16'h0102, 16'h5555, 1'b1);
        idle_in(); flush = 1; step();
        idle_in(); upd_valid = 1; upd_pc = 16'h0104; upd_target = 16'h7777; upd_taken = 1;
        n_busy = busy ? 1 : 0;
        for (int i = 0; i < 20 && busy; i++) begin
            step();
            if (busy) n_busy++;
        end
        check("busy_len", 32'(n_busy), 32'(SETS));
        do_lookup(16'h0102);
        check("flushed_miss", 32'(pred_hit), 32'h0);
        do_lookup(16'h0104);
        check("dropped_upd", 32'(pred_hit), 32'h0);

        // fill set 1, touch way 0, then a fifth fill evicts the PLRU way (way 2)
        for (int k = 0; k < WAYS; k++) do_update(16'(16 * k + 2), 16'(16'h1000 + 16 * k), 1'b1);
        do_lookup(16'h0002);
        do_update(16'h0042, 16'h1040, 1'b1);
        do_lookup(16'h0002);
        check("way0_kept", 32'(pred_target), 32'h1000);
        do_lookup(16'h0022);
        check("way2_evicted", 32'(pred_hit), 32'h0);
        do_lookup(16'h0042);
        check("new_fill", 32'(pred_target), 32'h1040);

        // same-cycle update and lookup: read-old, then new
        idle_in(); lookup_valid = 1; lookup_pc = 16'h0002;
        upd_valid = 1; upd_pc = 16'h0002; upd_target = 16'h2000; upd_taken = 1; step();
        check("read_old", 32'(pred_target), 32'h1000);
        do_lookup(16'h0002);
        check("read_new", 32'(pred_target), 32'h2000);

        // randomised traffic over a small tag pool so hits and evictions are frequent
        for (int i = 0; i < 1500; i++) begin
            idle_in();
            lookup_valid = ($urandom_range(9) < 7);
            lookup_pc    = 16'(($urandom_range(3) << 4) | ($urandom_range(7) << 1) | $urandom_range(1));
            upd_valid    = ($urandom_range(9) < 5);
            upd_pc       = 16'(($urandom_range(3) << 4) | ($urandom_range(7) << 1) | $urandom_range(1));
            upd_target   = 16'($urandom);
            upd_taken    = ($urandom_range(3) != 0);
            flush        = ($urandom_range(59) == 0);
            step();
        end

        // reset in the middle of a flush
        idle_in(); flush = 1; step();
        idle_in(); step(); step();
        #2 rst_n = 0;
        #1;
        check("midflush_busy", 32'(busy), 32'h0);
        check("midflush_pv", 32'(pred_valid), 32'h0);
        m_reset();
        #2 rst_n = 1;
        for (int k = 0; k < 8; k++) begin
            do_lookup(16'(($urandom_range(3) << 4) | (k << 1)));
            check("post_rst_miss", 32'(pred_hit), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
